// File: rtl/ask4_symbol_slicer.sv
// 4-ASK receive slicer: picks one matched-filter sample per symbol, decides, reports error
// and tracks the reference level by block averaging. Optional MSE output: SLICER_ERR_PWR_EN.
module ask4_symbol_slicer #(
    parameter int SPS      = 4,
    parameter int AVG_LOG2 = 10,
    parameter int REF_INIT = 32768
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic [1:0]         phase_sel,
    input  logic signed [17:0] x_in,
    output logic [1:0]         sym_out,
    output logic               sym_valid,
    output logic signed [17:0] err_out,
    output logic signed [17:0] ref_level,
    output logic               avg_done,
    output logic [17:0]        err_pwr
);

    localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int ACC_W = 18 + AVG_LOG2;
    localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(SPS - 1);
    localparam logic [PH_W-1:0]     PH_ONE   = PH_W'(32'd1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = AVG_LOG2'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(32'd1);
    localparam logic signed [17:0]  REF_RST  = 18'(REF_INIT);

    function automatic logic signed [19:0] sext20(input logic signed [17:0] v);
        return {{2{v[17]}}, v};
    endfunction

    // -131072 has no positive counterpart in 1s17, so it folds onto full scale
    function automatic logic [17:0] abs_sat18(input logic signed [17:0] v);
        logic [17:0] r;
        if (v == 18'sh20000) begin
            r = 18'h1FFFF;
        end else if (v[17]) begin
            r = $unsigned(-v);
        end else begin
            r = $unsigned(v);
        end
        return r;
    endfunction

    function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
        logic signed [17:0] r;
        if (v > 20'sh1FFFF) begin
            r = 18'sh1FFFF;
        end else if (v < 20'shE0000) begin
            r = 18'sh20000;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction

    logic [PH_W-1:0]     phase_cnt_r;
    logic [PH_W-1:0]     sample_idx_s;
    logic [1:0]          phase_lat_r;
    logic [1:0]          phase_eff_s;
    logic                capture_s;
    logic signed [17:0]  cap_x_r;
    logic                cap_vld_r;
    logic signed [19:0]  x_ext_s;
    logic signed [19:0]  ref_ext_s;
    logic signed [19:0]  half_s;
    logic signed [19:0]  three_s;
    logic signed [19:0]  ideal_s;
    logic [1:0]          dec_sym_s;
    logic signed [17:0]  dec_err_s;
    logic [17:0]         abs_s;
    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [AVG_LOG2-1:0] sym_cnt_r;
    logic                win_end_s;

    // Index of the current sample and whether it is the one to decide on
    always_comb begin
        sample_idx_s = {PH_W{1'b0}};
        phase_eff_s  = phase_lat_r;
        capture_s    = 1'b0;
        if (sym_clk_en) begin
            sample_idx_s = {PH_W{1'b0}};
        end else if (phase_cnt_r == PH_LAST) begin
            sample_idx_s = {PH_W{1'b0}};
        end else begin
            sample_idx_s = phase_cnt_r + PH_ONE;
        end
        // the boundary sample already uses the phase being latched with it
        if (sam_clk_en && sym_clk_en) begin
            phase_eff_s = phase_sel;
        end else begin
            phase_eff_s = phase_lat_r;
        end
        if (sam_clk_en && (32'(phase_eff_s) < 32'(SPS)) &&
            (32'(sample_idx_s) == 32'(phase_eff_s))) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Phase counter, phase latch and capture register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            phase_cnt_r <= {PH_W{1'b0}};
            phase_lat_r <= 2'b00;
            cap_x_r     <= 18'sd0;
            cap_vld_r   <= 1'b0;
        end else begin
            cap_vld_r <= capture_s;
            if (sam_clk_en) begin
                phase_cnt_r <= sample_idx_s;
            end
            if (sam_clk_en && sym_clk_en) begin
                phase_lat_r <= phase_sel;
            end
            if (capture_s) begin
                cap_x_r <= x_in;
            end
        end
    end

    // Decision regions, ideal level, error and window accumulation terms
    always_comb begin
        x_ext_s   = sext20(cap_x_r);
        ref_ext_s = sext20(ref_level);
        half_s    = ref_ext_s >>> 1;
        three_s   = ref_ext_s + half_s;
        dec_sym_s = 2'b00;
        ideal_s   = 20'sd0;
        if (x_ext_s >= ref_ext_s) begin
            dec_sym_s = 2'b11;
            ideal_s   = three_s;
        end else if (x_ext_s >= 20'sd0) begin
            dec_sym_s = 2'b10;
            ideal_s   = half_s;
        end else if (x_ext_s >= -ref_ext_s) begin
            dec_sym_s = 2'b01;
            ideal_s   = -half_s;
        end else begin
            dec_sym_s = 2'b00;
            ideal_s   = -three_s;
        end
        dec_err_s = sat18(x_ext_s - ideal_s);
        abs_s     = abs_sat18(cap_x_r);
        acc_sum_s = acc_r + {{AVG_LOG2{1'b0}}, abs_s};
        win_end_s = (sym_cnt_r == CNT_LAST);
    end

    // Decision outputs and reference window; the closing symbol still slices on the old level
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            err_out   <= 18'sd0;
            avg_done  <= 1'b0;
            ref_level <= REF_RST;
            acc_r     <= {ACC_W{1'b0}};
            sym_cnt_r <= {AVG_LOG2{1'b0}};
        end else begin
            sym_valid <= cap_vld_r;
            avg_done  <= 1'b0;
            if (cap_vld_r) begin
                sym_out <= dec_sym_s;
                err_out <= dec_err_s;
                if (win_end_s) begin
                    ref_level <= acc_sum_s[AVG_LOG2 +: 18];
                    acc_r     <= {ACC_W{1'b0}};
                    sym_cnt_r <= {AVG_LOG2{1'b0}};
                    avg_done  <= 1'b1;
                end else begin
                    acc_r     <= acc_sum_s;
                    sym_cnt_r <= sym_cnt_r + CNT_ONE;
                end
            end
        end
    end

`ifdef SLICER_ERR_PWR_EN
    logic signed [35:0] err_sq_s;
    logic [17:0]        err_sq_q_s;
    logic [ACC_W-1:0]   pwr_acc_r;
    logic [ACC_W-1:0]   pwr_sum_s;
    logic [17:0]        err_pwr_r;

    // Squared error in 2s34, kept as a 0.17 magnitude
    always_comb begin
        err_sq_s   = $signed({{18{dec_err_s[17]}}, dec_err_s}) *
                     $signed({{18{dec_err_s[17]}}, dec_err_s});
        err_sq_q_s = err_sq_s[34:17];
        pwr_sum_s  = pwr_acc_r + {{AVG_LOG2{1'b0}}, err_sq_q_s};
    end

    // Error power accumulator sharing the reference window boundaries
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pwr_acc_r <= {ACC_W{1'b0}};
            err_pwr_r <= 18'd0;
        end else if (cap_vld_r) begin
            if (win_end_s) begin
                err_pwr_r <= pwr_sum_s[AVG_LOG2 +: 18];
                pwr_acc_r <= {ACC_W{1'b0}};
            end else begin
                pwr_acc_r <= pwr_sum_s;
            end
        end else begin
            pwr_acc_r <= pwr_acc_r;
        end
    end

    assign err_pwr = err_pwr_r;
`else
    assign err_pwr = 18'd0;
`endif

endmodule

// File: tb/tb_ask4_symbol_slicer.sv
// Scoreboard bench for ask4_symbol_slicer (AVG_LOG2=4); expectations come from a behavioural model.
module tb_ask4_symbol_slicer;

    localparam int SPS      = 4;
    localparam int AVG_LOG2 = 4;
    localparam int WIN      = 16;
    localparam int REF_INIT = 32768;
`ifdef SLICER_ERR_PWR_EN
    localparam bit PWR_EN = 1'b1;
`else
    localparam bit PWR_EN = 1'b0;
`endif

    logic               sys_clk = 1'b0;
    logic               reset;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic [1:0]         phase_sel;
    logic signed [17:0] x_in;
    logic [1:0]         sym_out;
    logic               sym_valid;
    logic signed [17:0] err_out;
    logic signed [17:0] ref_level;
    logic               avg_done;
    logic [17:0]        err_pwr;

    ask4_symbol_slicer #(
        .SPS      (SPS),
        .AVG_LOG2 (AVG_LOG2),
        .REF_INIT (REF_INIT)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .phase_sel  (phase_sel),
        .x_in       (x_in),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .err_out    (err_out),
        .ref_level  (ref_level),
        .avg_done   (avg_done),
        .err_pwr    (err_pwr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cyc;
        int sym;
        int err;
        int avg;
        int ref_lv;
        int pwr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   m_ref, m_acc, m_cnt, m_pacc, m_pwr, m_lat;
    bit   stray_sym = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void slice_model(input int x, input int r, output int s, output int e);
        int half;
        int three;
        int ideal;
        half  = r / 2;
        three = r + half;
        if (x >= r) begin
            s = 3; ideal = three;
        end else if (x >= 0) begin
            s = 2; ideal = half;
        end else if (x >= -r) begin
            s = 1; ideal = -half;
        end else begin
            s = 0; ideal = -three;
        end
        e = x - ideal;
        if (e > 131071) e = 131071;
        if (e < -131072) e = -131072;
    endfunction

    task automatic model_reset();
        m_ref  = REF_INIT;
        m_acc  = 0;
        m_cnt  = 0;
        m_pacc = 0;
        m_pwr  = 0;
        m_lat  = 0;
        sb_q.delete();
    endtask

    task automatic model_push(input int x);
        exp_t   e;
        int     s;
        int     er;
        int     a;
        longint sq;
        slice_model(x, m_ref, s, er);
        a  = (x < 0) ? ((x == -131072) ? 131071 : -x) : x;
        sq = (longint'(er) * longint'(er)) / 131072;
        e.avg = 0;
        if (m_cnt == WIN - 1) begin
            m_ref  = (m_acc + a) / WIN;
            m_pwr  = int'((longint'(m_pacc) + sq) / WIN);
            m_acc  = 0;
            m_pacc = 0;
            m_cnt  = 0;
            e.avg  = 1;
        end else begin
            m_acc  += a;
            m_pacc += int'(sq);
            m_cnt++;
        end
        e.cyc    = cyc + 2;
        e.sym    = s;
        e.err    = er;
        e.ref_lv = m_ref;
        e.pwr    = PWR_EN ? m_pwr : 0;
        sb_q.push_back(e);
    endtask

    task automatic send_sample(input bit sym, input int x, input bit cap, input int gap);
        sam_clk_en = 1'b1;
        sym_clk_en = sym;
        x_in       = x[17:0];
        if (cap && !reset) model_push(x);
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            sym_clk_en = stray_sym;
            @(negedge sys_clk);
        end
        sym_clk_en = 1'b0;
    endtask

    // phase_sel shows ph_now on the boundary sample and ph_mid afterwards
    task automatic send_symbol(input int base, input int step, input int ph_now,
                               input int ph_mid, input bit with_sym, input int gap);
        phase_sel = ph_now[1:0];
        if (with_sym) m_lat = ph_now;
        for (int k = 0; k < SPS; k++) begin
            if (k == 1) phase_sel = ph_mid[1:0];
            send_sample(with_sym && (k == 0), base + step * k, (k == m_lat), gap);
        end
    endtask

    task automatic wait_drain();
        int budget = 40;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge sys_clk);
            budget--;
        end
        check_eq("drain", sb_q.size(), 0);
        @(negedge sys_clk);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            sam_clk_en = 1'b1;
            sym_clk_en = (i % SPS == 0);
            x_in       = 18'sd50000;
            @(negedge sys_clk);
        end
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        check_eq("rst_ref", ref_level, REF_INIT);
        check_eq("rst_valid", sym_valid, 0);
        check_eq("rst_err", err_out, 0);
        check_eq("rst_avg", avg_done, 0);
        check_eq("rst_sym", sym_out, 0);
        check_eq("rst_pwr", err_pwr, 0);
        reset = 1'b0;
    endtask

    // Scoreboard: every sym_valid must match the oldest expectation at the predicted cycle
    always @(negedge sys_clk) begin
        if (reset) begin
            check_eq("valid_in_reset", sym_valid, 0);
        end else if (sym_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", sym_valid, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("latency", cyc, mon_e.cyc);
                check_eq("sym_out", sym_out, mon_e.sym);
                check_eq("err_out", err_out, mon_e.err);
                check_eq("avg_done", avg_done, mon_e.avg);
                check_eq("ref_level", ref_level, mon_e.ref_lv);
                check_eq("err_pwr", err_pwr, mon_e.pwr);
            end
        end else begin
            check_eq("avg_idle", avg_done, 0);
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check_eq("missed_valid", sym_valid, 1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        phase_sel  = 2'd0;
        x_in       = 18'sd0;
        apply_reset(3);

        // constant +0.75, one sample every 4 clocks
        for (int i = 0; i < 5; i++) send_symbol(98304, 0, 0, 0, 1'b1, 3);
        wait_drain();
        check_eq("const_sym", sym_out, 3);
        check_eq("const_err", err_out, 49152);

        // phase selection: sample k carries 1000*k
        for (int i = 0; i < 3; i++) send_symbol(0, 1000, 2, 2, 1'b1, 0);
        wait_drain();
        check_eq("phase_sym", sym_out, 2);
        check_eq("phase_err", err_out, -14384);
        send_symbol(0, 1000, 2, 1, 1'b1, 0);
        send_symbol(0, 1000, 1, 1, 1'b1, 0);
        stray_sym = 1'b1;
        send_symbol(0, 1000, 3, 3, 1'b0, 1);
        stray_sym = 1'b0;
        send_symbol(0, 1000, 2, 2, 1'b1, 0);
        wait_drain();

        // one full averaging window from a clean start
        apply_reset(2);
        for (int i = 0; i < WIN; i++) send_symbol((i % 2 == 0) ? 65536 : -65536, 0, 0, 0, 1'b1, 0);
        wait_drain();
        check_eq("alt_ref", ref_level, 65536);
        send_symbol(60000, 0, 0, 0, 1'b1, 0);
        send_symbol(60000, 0, 0, 0, 1'b1, 0);
        wait_drain();
        check_eq("pos_sym", sym_out, 2);
        check_eq("pos_err", err_out, 27232);
        send_symbol(65536, 0, 0, 0, 1'b1, 0);
        send_symbol(0, 0, 0, 0, 1'b1, 0);
        send_symbol(-70000, 0, 0, 0, 1'b1, 1);
        wait_drain();
        check_eq("neg_sym", sym_out, 0);
        check_eq("neg_err", err_out, 28304);
        send_symbol(-65536, 0, 0, 0, 1'b1, 0);
        send_symbol(-70000, 0, 0, 0, 1'b1, 0);
        wait_drain();

        // reset after 7 symbols of the new window discards it
        apply_reset(2);
        for (int i = 0; i < WIN; i++) send_symbol((i % 2 == 0) ? 65536 : -65536, 0, 0, 0, 1'b1, 0);
        wait_drain();
        check_eq("realign_ref", ref_level, 65536);
        for (int i = 0; i < WIN; i++) send_symbol(40000, 0, 0, 0, 1'b1, 0);
        wait_drain();
        check_eq("mse_err", err_out, 7232);
        check_eq("mse_ref", ref_level, 40000);
        check_eq("mse_pwr", err_pwr, PWR_EN ? 399 : 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
